// File: rtl/mul_div_unit.sv
// Sequential signed multiply/divide unit.
// MUL: radix-2 Booth, one iteration per clock, exact 64-bit product.
// DIV: restoring division on operand magnitudes, then sign correction.
// Zresult = product for MUL, {remainder, quotient} for DIV.
module mul_div_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [63:0] Zresult
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, next_state;

    // Operation context latched on the accept edge
    logic        op_q;        // 0 = MUL, 1 = DIV
    logic [31:0] m_q;         // MUL: multiplicand A; DIV: |divisor|
    logic        neg_quo_q;   // DIV: quotient must be negated in FIX
    logic        neg_rem_q;   // DIV: remainder must be negated in FIX
    logic [4:0]  count_q;     // iteration index 0..31

    // Shared partial registers
    // MUL: {hi_q, lo_q, qm1_q} is the Booth accumulator/multiplier/extra bit
    // DIV: hi_q is the partial remainder, lo_q shifts dividend out, quotient in
    logic [32:0] hi_q;
    logic [31:0] lo_q;
    logic        qm1_q;

    logic        zero_div;
    logic [31:0] a_mag, b_mag;

    logic [32:0] hi_nxt;
    logic [31:0] lo_nxt;
    logic        qm1_nxt;
    logic [32:0] booth_sum;
    logic [32:0] shifted_rem;
    logic [32:0] trial;
    logic [31:0] quo_fix, rem_fix;
    logic [63:0] fix_result;

    assign zero_div = op && (B == 32'd0);
    assign a_mag    = A[31] ? (~A + 32'd1) : A;
    assign b_mag    = B[31] ? (~B + 32'd1) : B;

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so no path through the case leaves next_state
        // unassigned, which would infer a latch.
        next_state = state;
        case (state)
            IDLE: if (start) next_state = zero_div ? DONE : CALC;
            CALC: if (count_q == 5'd31) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One Booth step or one restoring-division step from the current partials
    always_comb begin
        booth_sum   = hi_q;
        shifted_rem = {hi_q[31:0], lo_q[31]};
        trial       = shifted_rem - {1'b0, m_q};
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        qm1_nxt     = qm1_q;
        if (!op_q) begin
            // Pair (q0, q-1): 01 adds the multiplicand, 10 subtracts it
            case ({lo_q[0], qm1_q})
                2'b01:   booth_sum = hi_q + {m_q[31], m_q};
                2'b10:   booth_sum = hi_q - {m_q[31], m_q};
                default: booth_sum = hi_q;
            endcase
            hi_nxt  = {booth_sum[32], booth_sum[32:1]};
            lo_nxt  = {booth_sum[0], lo_q[31:1]};
            qm1_nxt = lo_q[0];
        end else if (!trial[32]) begin
            // Divisor fits: keep the difference and shift in a 1
            hi_nxt = trial;
            lo_nxt = {lo_q[30:0], 1'b1};
        end else begin
            // Divisor does not fit: restore and shift in a 0
            hi_nxt = shifted_rem;
            lo_nxt = {lo_q[30:0], 1'b0};
        end
    end

    // Sign correction and final result selection
    always_comb begin
        quo_fix = neg_quo_q ? (~lo_q + 32'd1) : lo_q;
        rem_fix = neg_rem_q ? (~hi_q[31:0] + 32'd1) : hi_q[31:0];
        fix_result = op_q ? {rem_fix, quo_fix} : {hi_q[31:0], lo_q};
    end

    // Datapath registers: operand latch, iteration, result/flag update
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q        <= 1'b0;
            m_q         <= 32'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            count_q     <= 5'd0;
            hi_q        <= 33'd0;
            lo_q        <= 32'd0;
            qm1_q       <= 1'b0;
            div_by_zero <= 1'b0;
            Zresult     <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        count_q     <= 5'd0;
                        hi_q        <= 33'd0;
                        qm1_q       <= 1'b0;
                        div_by_zero <= zero_div;
                        if (zero_div) begin
                            Zresult <= {A, 32'hFFFF_FFFF};
                        end
                        if (op) begin
                            m_q       <= b_mag;
                            lo_q      <= a_mag;
                            neg_quo_q <= A[31] ^ B[31];
                            neg_rem_q <= A[31];
                        end else begin
                            m_q       <= A;
                            lo_q      <= B;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    hi_q    <= hi_nxt;
                    lo_q    <= lo_nxt;
                    qm1_q   <= qm1_nxt;
                    count_q <= count_q + 5'd1;
                end
                FIX: begin
                    Zresult <= fix_result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, start held
// during an operation, mid-operation clear, and randomized operations
// checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clock;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] Zresult;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .Zresult     (Zresult)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: signed arithmetic on 64-bit integers
    function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) return sa * sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issues one operation from IDLE (called #1 after an edge) and checks
    // latency, busy cycles, flag, result, and single-cycle done.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input string name);
        logic [63:0] exp_z;
        bit          exp_dz;
        int          exp_lat, exp_busy, cycles, busy_cnt;
        exp_z    = ref_result(o, a, b);
        exp_dz   = o && (b == 32'd0);
        exp_lat  = exp_dz ? 1 : 34;
        exp_busy = exp_dz ? 0 : 33;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clock); #1;
        cycles = 1;
        busy_cnt = 0;
        n_checks++;
        if (div_by_zero !== exp_dz) begin
            $display("FAIL %s flag after accept: got %0b want %0b", name, div_by_zero, exp_dz);
            n_fail++;
        end
        while (1) begin
            if (!hold) start = 1'b0;
            A = $urandom; B = $urandom; op = 1'($urandom);
            if (busy) busy_cnt++;
            if (busy && done) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s busy and done together at cycle %0d", name, cycles);
            end
            if (done || cycles >= 40) break;
            @(posedge clock); #1;
            cycles++;
        end
        n_checks++;
        if (!done) begin
            $display("FAIL %s timeout: no done within %0d edges", name, cycles);
            n_fail++;
        end else if (cycles !== exp_lat) begin
            $display("FAIL %s latency: got %0d edges want %0d", name, cycles, exp_lat);
            n_fail++;
        end
        n_checks++;
        if (busy_cnt !== exp_busy) begin
            $display("FAIL %s busy cycles: got %0d want %0d", name, busy_cnt, exp_busy);
            n_fail++;
        end
        n_checks++;
        if (Zresult !== exp_z) begin
            $display("FAIL %s Zresult: got %h want %h", name, Zresult, exp_z);
            n_fail++;
        end
        n_checks++;
        if (div_by_zero !== exp_dz) begin
            $display("FAIL %s div_by_zero at done: got %0b want %0b", name, div_by_zero, exp_dz);
            n_fail++;
        end
        @(posedge clock); #1;
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL %s after done: done=%0b busy=%0b want 0/0", name, done, busy);
            n_fail++;
        end
        n_checks++;
        if (Zresult !== exp_z || div_by_zero !== exp_dz) begin
            $display("FAIL %s hold in idle: Z=%h dz=%0b want %h/%0b", name, Zresult, div_by_zero, exp_z, exp_dz);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || Zresult !== 64'd0) begin
            $display("FAIL reset outputs: busy=%0b done=%0b dz=%0b Z=%h want all 0", busy, done, div_by_zero, Zresult);
            n_fail++;
        end
        clear = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_mul_directed();
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_x_m3");
        n_checks++;
        if (Zresult !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            $display("FAIL mul_7_x_m3 literal: got %h want ffffffffffffffeb", Zresult);
            n_fail++;
        end
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mul_min_x_min");
        n_checks++;
        if (Zresult !== 64'h4000_0000_0000_0000) begin
            $display("FAIL mul_min_x_min literal: got %h want 4000000000000000", Zresult);
            n_fail++;
        end
    endtask

    task automatic test_div_directed();
        run_op(1'b1, 32'hFFFF_FFEF, 32'd5, 1'b0, "div_m17_by_5");
        n_checks++;
        if (Zresult !== 64'hFFFF_FFFE_FFFF_FFFD) begin
            $display("FAIL div_m17_by_5 literal: got %h want fffffffefffffffd", Zresult);
            n_fail++;
        end
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_by_m1");
        n_checks++;
        if (Zresult !== 64'h0000_0000_8000_0000 || div_by_zero !== 1'b0) begin
            $display("FAIL div_min_by_m1 literal: got %h dz=%0b want 0000000080000000/0", Zresult, div_by_zero);
            n_fail++;
        end
    endtask

    task automatic test_div_by_zero();
        run_op(1'b1, 32'h1234_5678, 32'd0, 1'b0, "div_by_zero");
        n_checks++;
        if (Zresult !== 64'h1234_5678_FFFF_FFFF || div_by_zero !== 1'b1) begin
            $display("FAIL div_by_zero literal: got %h dz=%0b want 12345678ffffffff/1", Zresult, div_by_zero);
            n_fail++;
        end
        // Next accept (MUL) must clear the flag; run_op checks it right after accept
        run_op(1'b0, 32'd9, 32'd11, 1'b0, "mul_after_dz");
    endtask

    task automatic test_hold_start();
        run_op(1'b0, 32'h0001_2345, 32'hFFFF_8001, 1'b1, "hold_mul");
        run_op(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFF9, 1'b1, "hold_div");
    endtask

    task automatic test_clear_abort();
        int seen_done;
        start = 1'b1; op = 1'b0; A = 32'd1234; B = 32'd5678;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || Zresult !== 64'd0) begin
            $display("FAIL clear_abort immediate: busy=%0b done=%0b dz=%0b Z=%h want all 0", busy, done, div_by_zero, Zresult);
            n_fail++;
        end
        seen_done = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (done || busy) seen_done++;
        end
        clear = 1'b1;
        repeat (30) begin
            @(posedge clock); #1;
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            $display("FAIL clear_abort activity: got %0d busy/done cycles want 0", seen_done);
            n_fail++;
        end
        run_op(1'b0, 32'd3, 32'd4, 1'b0, "mul_3x4_after_clear");
        n_checks++;
        if (Zresult !== 64'h0000_0000_0000_000C) begin
            $display("FAIL mul_3x4_after_clear literal: got %h want 000000000000000c", Zresult);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic [31:0] corners [5];
        logic [31:0] a, b;
        logic        o;
        corners[0] = 32'd0;
        corners[1] = 32'd1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            run_op(o, a, b, 1'($urandom_range(0, 1)), $sformatf("rand_%0d", i));
        end
    endtask

    initial begin
        clear = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_div_by_zero();
        test_hold_start();
        test_clear_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clock and clear.
REQ-002 The block SHALL expose `clock  in  1`: rising-edge clock shared with the datapath.
REQ-003 The block SHALL expose `clear  in  1`: asynchronous, active-low reset.
REQ-004 The block SHALL expose `start  in  1`: request a new operation, sampled only in IDLE.
REQ-005 The block SHALL expose `op  in  1`: 0 = signed MUL, 1 = signed DIV.
REQ-006 The block SHALL expose `A  in  32`: multiplicand or dividend, taken from the Y register.
REQ-007 The block SHALL expose `B  in  32`: multiplier or divisor, taken from BusMuxOut.
REQ-008 The block SHALL expose `busy  out  1`: high in CALC and FIX.
REQ-009 The block SHALL expose `done  out  1`: one-cycle pulse, high in DONE only.
REQ-010 The block SHALL expose `div_by_zero  out  1`: flag for DIV with B = 0.
REQ-011 The block SHALL expose `Zresult  out  64`: feeds the Z register input; [63:32] is the Zhigh half, [31:0] is the Zlow half.

Function
REQ-012 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-013 In IDLE with start = 1 at a rising edge, the block SHALL latch A, B and op; later changes on A, B or op SHALL NOT affect the operation.
REQ-014 On that accept edge with op = 0, or op = 1 and B != 0, the next state SHALL be CALC with the iteration counter at 0.
REQ-015 On that accept edge with op = 1 and B = 0, the next state SHALL be DONE directly, with Zresult = {A, 32'hFFFFFFFF} and div_by_zero = 1.
REQ-016 CALC SHALL perform exactly one iteration per clock for 32 clocks; after the 32nd iteration edge the state SHALL become FIX.
REQ-017 MUL SHALL use radix-2 Booth on the two's-complement operands and produce the exact signed 64-bit product.
REQ-018 DIV SHALL run restoring or non-restoring division on operand magnitudes; the quotient SHALL truncate toward zero.
REQ-019 DIV remainder SHALL take the sign of the dividend, with |remainder| < |divisor|.
REQ-020 FIX SHALL apply sign correction, register the result into Zresult, and transition to DONE on the next edge.
REQ-021 Zresult for MUL SHALL be the 64-bit product.
REQ-022 Zresult for DIV SHALL be {remainder, quotient}.
REQ-023 For DIV 0x80000000 / 0xFFFFFFFF, the quotient SHALL wrap to 0x80000000 and the remainder SHALL be 0, with no flag.
REQ-024 DONE SHALL last one cycle and then return to IDLE.
REQ-025 Latency from the accept edge SHALL be 34 edges to done high for a normal operation, and 1 edge for divide-by-zero.
REQ-026 Zresult and div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-027 div_by_zero SHALL clear on the next accept edge.
REQ-028 start SHALL be ignored in CALC, FIX and DONE; it is not queued.
REQ-029 busy and done SHALL never be high in the same cycle.

Reset
REQ-030 While clear = 0, independent of clock, the state SHALL be IDLE and busy, done, div_by_zero and Zresult SHALL be 0.
REQ-031 While clear = 0, the counter and all operand and partial registers SHALL be cleared.
REQ-032 clear asserted mid-operation SHALL abort the operation with no done pulse; the first start after clear rises SHALL behave as from power-up.

Verification
REQ-033 The bench SHALL cover: MUL A = 7, B = 0xFFFFFFFD (-3) -> done 34 edges after accept, Zresult = 0xFFFFFFFF_FFFFFFEB, busy high for 33 cycles.
REQ-034 The bench SHALL cover: MUL A = B = 0x80000000 -> Zresult = 0x40000000_00000000.
REQ-035 The bench SHALL cover: DIV A = 0xFFFFFFEF (-17), B = 5 -> Zresult = 0xFFFFFFFE_FFFFFFFD (rem -2, quo -3), div_by_zero = 0.
REQ-036 The bench SHALL cover: DIV A = 0x12345678, B = 0 -> done 1 edge after accept, div_by_zero = 1, Zresult = 0x12345678_FFFFFFFF; the next MUL accept clears the flag.
REQ-037 The bench SHALL cover: start held high and A/B changed during CALC -> result matches the latched operands, and exactly one done pulse occurs per accept.
REQ-038 The bench SHALL cover: clear pulsed low at CALC iteration 10 -> outputs 0 immediately, no done; then MUL 3 × 4 -> Zresult = 0x00000000_0000000C after 34 edges.
